program_loader: RTL and testbench

Boot sequencer and program loader for the single-cycle RISC-V core. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into the instruction memory. It holds the core in reset for the whole load and releases it only after the last word has been written. It sits between the host link (UART receiver or testbench) and the program ROM/RAM write port, and drives the core's `reset` input.

---
 rtl/program_loader.sv | 123 ++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs little-endian words into
// instruction memory, and keeps the core in reset until the last word is written.
module program_loader #(
    parameter int unsigned memory_depth = 64,
    parameter logic [31:0] base_address = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_load,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
    // the source holds byte_data until then, and byte_ready never depends on inputs.
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_CHECK, S_DATA, S_WRITE, S_RUN, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] partial_q, partial_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        xfer;

    assign byte_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
    assign xfer       = byte_valid && byte_ready;
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_CHECK)
                     || (state_q == S_DATA) || (state_q == S_WRITE);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERROR);
    assign cpu_reset  = (state_q != S_RUN);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        lane_d    = lane_q;
        partial_d = partial_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start_load) state_d = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d[7:0] = byte_data;
                    state_d      = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = byte_data;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((count_q == 16'd0) || ({16'd0, count_q} > 32'(memory_depth))) begin
                    state_d = S_ERROR;
                end else begin
                    index_d = 16'd0;
                    lane_d  = 2'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (lane_q == 2'd3) begin
                        // Address and data are latched here so they are stable for the whole WRITE cycle.
                        wdata_d = {byte_data, partial_q};
                        addr_d  = base_address + {14'd0, index_q, 2'b00};
                        lane_d  = 2'd0;
                        state_d = S_WRITE;
                    end else begin
                        partial_d[{lane_q, 3'b000} +: 8] = byte_data;
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                index_d = index_q + 16'd1;
                state_d = (index_d == count_q) ? S_RUN : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= 16'd0;
            index_q   <= 16'd0;
            lane_q    <= 2'd0;
            partial_q <= 24'd0;
            addr_q    <= base_address;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            lane_q    <= lane_d;
            partial_q <= partial_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a write scoreboard fed by the stimulus and
// drained by a monitor, plus level checks on the control outputs.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_load = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, cpu_reset, busy, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start;
    logic [63:0] exp_q[$];

    program_loader #(.memory_depth(64), .base_address(BASE)) dut (
        .clk(clk), .reset(reset), .start_load(start_load),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    // driver tasks: all drives happen #1 after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accepted;
        int budget;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        accepted   = 1'b0;
        budget     = 0;
        while (!accepted && budget < 50) begin
            @(negedge clk);
            accepted = byte_ready;
            tick();
            budget++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got no accept expected byte %h accepted", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic send_header(input logic [15:0] n, input bit rnd);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 0;
        while (!done && budget < 400) begin
            tick();
            budget++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        bit stuck;
        repeat (3) tick();
        reset = 1'b0;

        // reset values and idle hold
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_busy_done_error", {29'd0, busy, done, error}, 32'd0);
        stuck = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!cpu_reset || byte_ready) stuck = 1'b0;
        end
        check("idle_hold_20", {31'd0, stuck}, 32'd1);

        // N=2 load, byte_valid held high
        pulse_start();
        t_start = cyc;
        check("start_ready", {30'd0, byte_ready, busy}, 32'd3);
        exp_q.push_back({BASE, 32'h00A0_0513});
        exp_q.push_back({BASE + 32'd4, 32'h0000_006F});
        send_header(16'd2, 0);
        send_word(32'h00A0_0513, 0);
        send_word(32'h0000_006F, 0);
        byte_valid = 1'b0;
        check("last_write_cpu_held", {30'd0, imem_we, cpu_reset}, 32'd3);
        tick();
        check("run_after_write", {29'd0, cpu_reset, done, busy}, 32'd2);
        check("min_load_cycles", cyc - t_start, 32'd13);

        // restart from RUN, then same stream with random gaps
        pulse_start();
        check("restart_cpu_reset", {30'd0, cpu_reset, done}, 32'd2);
        exp_q.push_back({BASE, 32'h00A0_0513});
        exp_q.push_back({BASE + 32'd4, 32'h0000_006F});
        send_header(16'd2, 1);
        send_word(32'h00A0_0513, 1);
        send_word(32'h0000_006F, 1);
        byte_valid = 1'b0;
        wait_done("gap_load_done");
        check("gap_queue_empty", exp_q.size(), 32'd0);

        // bad headers: N=0 and N=65
        pulse_start();
        send_header(16'd0, 0);
        byte_valid = 1'b0;
        repeat (2) tick();
        check("n0_error", {29'd0, error, cpu_reset, done}, 32'd6);
        pulse_start();
        send_header(16'd65, 0);
        byte_valid = 1'b0;
        repeat (2) tick();
        check("n65_error", {29'd0, error, cpu_reset, busy}, 32'd6);

        // recovery with N=1
        pulse_start();
        check("err_cleared", {31'd0, error}, 32'd0);
        exp_q.push_back({BASE, 32'h1234_5678});
        send_header(16'd1, 0);
        send_word(32'h1234_5678, 0);
        byte_valid = 1'b0;
        wait_done("recover_done");

        // N = memory_depth is accepted
        pulse_start();
        send_header(16'd64, 0);
        for (int w = 0; w < 64; w++) begin
            logic [7:0] b;
            b = 8'(4 * w);
            exp_q.push_back({BASE + 32'(4 * w), b + 8'd3, b + 8'd2, b + 8'd1, b});
            send_word({b + 8'd3, b + 8'd2, b + 8'd1, b}, 0);
        end
        byte_valid = 1'b0;
        wait_done("full_depth_done");
        check("full_depth_queue", exp_q.size(), 32'd0);

        // reset after the 6th data byte: exactly one write
        pulse_start();
        exp_q.push_back({BASE, 32'hA1A2_A3A4});
        send_header(16'd2, 0);
        send_word(32'hA1A2_A3A4, 0);
        send_byte(8'hB4, 0);
        send_byte(8'hB3, 0);
        byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ctrl", {27'd0, cpu_reset, byte_ready, busy, done, error}, 32'h10);
        check("midrst_we", {31'd0, imem_we}, 32'd0);
        check("midrst_addr", imem_addr, BASE);
        check("midrst_wdata", imem_wdata, 32'd0);
        repeat (10) tick();
        check("midrst_queue", exp_q.size(), 32'd0);
        check("midrst_still_held", {31'd0, cpu_reset}, 32'd1);

        // N=1 load with start_load held high throughout
        pulse_start();
        start_load = 1'b1;
        exp_q.push_back({BASE, 32'hDEAD_BEEF});
        send_header(16'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
        start_load = 1'b0;
        byte_valid = 1'b0;
        tick();
        check("deadbeef_run", {30'd0, done, cpu_reset}, 32'd2);
        repeat (5) tick();
        check("deadbeef_stays_run", {30'd0, done, busy}, 32'd2);
        check("final_queue", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
